// File: rtl/regbus_arb_pkg.sv
// Shared types for the register-bus round-robin arbiter: default bus structs, FSM state
// encoding and the data word returned when the watchdog ends an access.
package regbus_arb_pkg;

  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_a48_d32_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_a48_d32_rsp_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StErr
  } arb_state_e;

  localparam logic [31:0] ArbTimeoutRdata = 32'hDEADBEEF;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first valid index searching upward from ptr_i + 1, wrapping at NumReq.
module rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  always_comb begin
    int unsigned cand;
    cand  = 0;
    idx_o = '0;
    any_o = 1'b0;
    // Offsets 1..NumReq visit every index once, the last being ptr_i itself.
    for (int unsigned off = 1; off <= NumReq; off++) begin
      cand = (32'(ptr_i) + off) % NumReq;
      if (!any_o && valid_i[cand[IdxW-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/regbus_rr_arbiter.sv
// Round-robin arbiter sharing one register-bus target among NumReq requesters.
// Define REGBUS_ARB_TIMEOUT_EN to add a watchdog that terminates accesses the target never ends.
module regbus_rr_arbiter
  import regbus_arb_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type         req_t         = reg_a48_d32_req_t,
  parameter type         rsp_t         = reg_a48_d32_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  req_t                      req_i [NumReq],
  output rsp_t                      rsp_o [NumReq],
  output req_t                      req_o,
  input  rsp_t                      rsp_i,
  output logic                      busy_o,
  output logic [$clog2(NumReq)-1:0] gnt_idx_o,
  output logic                      timeout_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  if (NumReq < 2 || TimeoutCycles < 2 || $bits(req_o.addr) != AddrWidth ||
      $bits(rsp_i.rdata) != DataWidth) begin : gen_bad_param
    $error("regbus_rr_arbiter: unsupported parameterisation");
  end

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d, ptr_q, ptr_d, pick_idx;
  logic [NumReq-1:0] valid_vec;
  logic              pick_any;

`ifdef REGBUS_ARB_TIMEOUT_EN
  localparam int unsigned     CntW   = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) valid_vec[k] = req_i[k].valid;
  end

  rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .valid_i (valid_vec),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef REGBUS_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    req_o   = '0;
    for (int unsigned k = 0; k < NumReq; k++) rsp_o[k] = '0;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          idx_d   = pick_idx;
          state_d = StBusy;
`ifdef REGBUS_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StBusy: begin
        req_o = req_i[idx_q];
        if (rsp_i.ready) begin
          rsp_o[idx_q] = rsp_i;
          ptr_d        = idx_q;
          state_d      = StIdle;
        end else if (!req_i[idx_q].valid) begin
          // Requester abandoned the access: release without a response.
          ptr_d   = idx_q;
          state_d = StIdle;
`ifdef REGBUS_ARB_TIMEOUT_EN
        end else if (cnt_q == CntMax) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
`ifdef REGBUS_ARB_TIMEOUT_EN
      StErr: begin
        rsp_o[idx_q].ready = 1'b1;
        rsp_o[idx_q].error = 1'b1;
        rsp_o[idx_q].rdata = DataWidth'(ArbTimeoutRdata);
        ptr_d              = idx_q;
        state_d            = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ptr_q   <= IdxW'(NumReq - 1);
`ifdef REGBUS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef REGBUS_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign gnt_idx_o = idx_q;
`ifdef REGBUS_ARB_TIMEOUT_EN
  assign timeout_o = (state_q == StErr);
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_regbus_rr_arbiter.sv
// Scoreboard bench for regbus_rr_arbiter: stimulus queues expected grants and responses,
// negedge monitors pop and compare. Watchdog cases follow REGBUS_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_regbus_rr_arbiter;
  import regbus_arb_pkg::*;

  localparam int N = 4;

  typedef struct { int idx; logic [47:0] addr; } gnt_exp_t;
  typedef struct { int port; logic [31:0] rdata; logic err; } rsp_exp_t;

  logic              clk = 1'b0;
  logic              rst_i;
  reg_a48_d32_req_t  req_s [N];
  reg_a48_d32_rsp_t  rsp_s [N];
  reg_a48_d32_req_t  req_o;
  reg_a48_d32_rsp_t  rsp_i, rsp_man;
  logic              auto_ready;
  logic              busy_o, timeout_o;
  logic [1:0]        gnt_idx_o;

  gnt_exp_t exp_gnt_q [$];
  rsp_exp_t exp_rsp_q [$];
  int n_vec = 0;
  int n_err = 0;
  logic prev_valid = 1'b0;

  regbus_rr_arbiter #(
    .NumReq        (N),
    .AddrWidth     (48),
    .DataWidth     (32),
    .TimeoutCycles (8),
    .req_t         (reg_a48_d32_req_t),
    .rsp_t         (reg_a48_d32_rsp_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .req_i     (req_s),
    .rsp_o     (rsp_s),
    .req_o     (req_o),
    .rsp_i     (rsp_i),
    .busy_o    (busy_o),
    .gnt_idx_o (gnt_idx_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  // Zero-wait target used for the contention phase.
  always_comb begin
    rsp_i = rsp_man;
    if (auto_ready && req_o.valid) begin
      rsp_i.ready = 1'b1;
      rsp_i.error = 1'b0;
      rsp_i.rdata = req_o.addr[31:0] ^ 32'hC0DE0000;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic [47:0] a);
    req_s[k].valid = v;
    req_s[k].addr  = a;
    req_s[k].write = 1'b0;
    req_s[k].wdata = '0;
    req_s[k].wstrb = '0;
  endtask

  task automatic exp_gnt(input int i, input logic [47:0] a);
    gnt_exp_t e;
    e.idx  = i;
    e.addr = a;
    exp_gnt_q.push_back(e);
  endtask

  task automatic exp_rsp(input int p, input logic [31:0] d, input logic er);
    rsp_exp_t e;
    e.port  = p;
    e.rdata = d;
    e.err   = er;
    exp_rsp_q.push_back(e);
  endtask

  task automatic target_ready(input logic [31:0] d);
    rsp_man.ready = 1'b1;
    rsp_man.error = 1'b0;
    rsp_man.rdata = d;
  endtask

  // Grant monitor: every rising edge of req_o.valid is a new grant.
  always @(negedge clk) begin
    gnt_exp_t e;
    if (req_o.valid && !prev_valid) begin
      if (exp_gnt_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_grant: got idx %0d expected none", gnt_idx_o);
      end else begin
        e = exp_gnt_q.pop_front();
        check("grant_idx", 64'(gnt_idx_o), 64'(e.idx));
        check("grant_addr", 64'(req_o.addr), 64'(e.addr));
      end
    end
    prev_valid = req_o.valid;
  end

  // Response monitor: any ready on rsp_o must match the head of the response queue.
  always @(negedge clk) begin
    int nz;
    int nr;
    rsp_exp_t r;
    nz = 0;
    nr = 0;
    for (int k = 0; k < N; k++) begin
      if (rsp_s[k] != '0) nz++;
      if (rsp_s[k].ready) begin
        nr++;
        if (exp_rsp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got port %0d rdata %0h expected none", k, rsp_s[k].rdata);
        end else begin
          r = exp_rsp_q.pop_front();
          check("rsp_port", 64'(k), 64'(r.port));
          check("rsp_rdata", 64'(rsp_s[k].rdata), 64'(r.rdata));
          check("rsp_error", 64'(rsp_s[k].error), 64'(r.err));
        end
      end
    end
    if (nr != 0) check("rsp_onehot", 64'(nz), 64'd1);
    else if (nz != 0) check("rsp_idle_zero", 64'(nz), 64'd0);
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int order [5];
    int stuck;
    order = '{0, 1, 2, 3, 0};
    rst_i = 1'b1;
    auto_ready = 1'b0;
    rsp_man = '0;
    for (int k = 0; k < N; k++) drive(k, 1'b0, '0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_gnt", 64'(gnt_idx_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    check("rst_req_o", 64'(req_o.valid), 64'd0);

    // All requesters contend with a zero-wait target: 0,1,2,3,0.
    tick();
    rst_i = 1'b0;
    auto_ready = 1'b1;
    for (int k = 0; k < N; k++) drive(k, 1'b1, 48'h2000 + 48'(k * 16));
    for (int j = 0; j < 5; j++) begin
      exp_gnt(order[j], 48'h2000 + 48'(order[j] * 16));
      exp_rsp(order[j], (32'h2000 + 32'(order[j] * 16)) ^ 32'hC0DE0000, 1'b0);
    end
    for (int c = 0; c < 9; c++) begin
      tick();
      @(negedge clk);
      if (c % 2 == 0) begin
        check("cont_busy", 64'(busy_o), 64'd1);
        check("cont_gnt", 64'(gnt_idx_o), 64'(order[c / 2]));
      end else begin
        check("cont_idle", 64'(busy_o), 64'd0);
      end
    end
    tick();
    auto_ready = 1'b0;
    for (int k = 0; k < N; k++) drive(k, 1'b0, '0);
    @(negedge clk);
    check("cont_end_idle", 64'(busy_o), 64'd0);

    // Lone requester 2, ready on its 3rd BUSY cycle.
    tick();
    drive(2, 1'b1, 48'h1000);
    exp_gnt(2, 48'h1000);
    @(negedge clk);
    check("lat_before", 64'(req_o.valid), 64'd0);
    tick();
    @(negedge clk);
    check("lat_after", 64'(req_o.valid), 64'd1);
    tick();
    tick();
    target_ready(32'h12345678);
    exp_rsp(2, 32'h12345678, 1'b0);
    tick();
    rsp_man = '0;
    drive(2, 1'b0, '0);
    @(negedge clk);
    check("single_done", 64'(busy_o), 64'd0);

    // Requester 1 drops valid mid-access; then 1 and 3 contend (ptr=1 -> 3 first).
    tick();
    drive(1, 1'b1, 48'h3000);
    exp_gnt(1, 48'h3000);
    tick();
    tick();
    drive(1, 1'b0, '0);
    tick();
    @(negedge clk);
    check("abandon_idle", 64'(busy_o), 64'd0);
    drive(1, 1'b1, 48'h3100);
    drive(3, 1'b1, 48'h3300);
    exp_gnt(3, 48'h3300);
    tick();
    target_ready(32'h0BADF00D);
    exp_rsp(3, 32'h0BADF00D, 1'b0);
    tick();
    rsp_man = '0;
    drive(3, 1'b0, '0);
    exp_gnt(1, 48'h3100);
    tick();
    target_ready(32'h11110000);
    exp_rsp(1, 32'h11110000, 1'b0);
    tick();
    rsp_man = '0;
    drive(1, 1'b0, '0);
    // Ready while idle must be ignored.
    target_ready(32'hFFFF0000);
    @(negedge clk);
    check("idle_ready_ignored", 64'(busy_o), 64'd0);
    tick();
    rsp_man = '0;

    // Reset during BUSY; afterwards requester 0 has priority again.
    drive(2, 1'b1, 48'h4000);
    exp_gnt(2, 48'h4000);
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(0, 1'b1, 48'h4400);
    exp_gnt(0, 48'h4400);
    @(negedge clk);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_gnt", 64'(gnt_idx_o), 64'd0);
    check("mid_rst_req", 64'(req_o.valid), 64'd0);
    check("mid_rst_timeout", 64'(timeout_o), 64'd0);
    tick();
    target_ready(32'h44444444);
    exp_rsp(0, 32'h44444444, 1'b0);
    tick();
    rsp_man = '0;
    drive(0, 1'b0, '0);
    exp_gnt(2, 48'h4000);
    tick();
    target_ready(32'h22224444);
    exp_rsp(2, 32'h22224444, 1'b0);
    tick();
    rsp_man = '0;
    drive(2, 1'b0, '0);

`ifdef REGBUS_ARB_TIMEOUT_EN
    // Ready in the limit cycle wins over the watchdog.
    drive(1, 1'b1, 48'h5000);
    exp_gnt(1, 48'h5000);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 7) begin
        target_ready(32'h55555555);
        exp_rsp(1, 32'h55555555, 1'b0);
      end
      @(negedge clk);
      check("race_timeout", 64'(timeout_o), 64'd0);
    end
    tick();
    rsp_man = '0;
    drive(1, 1'b0, '0);
    @(negedge clk);
    check("race_idle", 64'(busy_o), 64'd0);
    check("race_timeout_after", 64'(timeout_o), 64'd0);

    // Silent target: ERR after 8 BUSY cycles, then requester 1 is granted.
    drive(1, 1'b1, 48'h6100);
    drive(2, 1'b1, 48'h6200);
    exp_gnt(2, 48'h6200);
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge clk);
      check("wd_busy", 64'(busy_o), 64'd1);
      check("wd_no_pulse", 64'(timeout_o), 64'd0);
    end
    tick();
    exp_rsp(2, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("wd_pulse", 64'(timeout_o), 64'd1);
    check("wd_req_off", 64'(req_o.valid), 64'd0);
    tick();
    drive(2, 1'b0, '0);
    exp_gnt(1, 48'h6100);
    @(negedge clk);
    check("wd_pulse_end", 64'(timeout_o), 64'd0);
    tick();
    target_ready(32'h61616161);
    exp_rsp(1, 32'h61616161, 1'b0);
    tick();
    rsp_man = '0;
    drive(1, 1'b0, '0);
`else
    // No watchdog: a silent target keeps the grant indefinitely.
    drive(0, 1'b1, 48'h7000);
    exp_gnt(0, 48'h7000);
    tick();
    stuck = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (busy_o && !timeout_o && req_o.valid) stuck++;
      tick();
    end
    check("no_wd_stuck", 64'(stuck), 64'd5000);
    target_ready(32'h70707070);
    exp_rsp(0, 32'h70707070, 1'b0);
    tick();
    rsp_man = '0;
    drive(0, 1'b0, '0);
`endif

    repeat (3) tick();
    check("gnt_queue_drained", 64'(exp_gnt_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
